// File: rtl/frame_segmenter.sv
// Overlapping frame segmenter: buffers an incoming sample stream in a
// circular buffer and replays it as FRAME_LEN-sample frames that advance
// by HOP samples, tagging each output with frame number and sample index.
module frame_segmenter #(
  parameter int I_BW       = 14,
  parameter int FRAME_LEN  = 1024,
  parameter int HOP        = 512,
  parameter int NUM_FRAMES = 89
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         di_en,
  input  logic signed [I_BW-1:0]       data_i,
  output logic                         di_rdy,
  output logic                         do_en,
  output logic signed [I_BW-1:0]       data_o,
  output logic [6:0]                   out_group_num,
  output logic [$clog2(FRAME_LEN)-1:0] out_group_idx
);

  localparam int IW    = $clog2(FRAME_LEN);
  localparam int AW    = IW + 1;
  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int FW    = AW + 1;

  typedef enum logic [1:0] {
    WAIT,
    EMIT,
    DONE
  } state_t;

  state_t                  state;
  logic signed [I_BW-1:0]  mem [DEPTH];
  logic [AW-1:0]           wp;
  logic [AW-1:0]           fs;
  logic [FW-1:0]           fill;
  logic [IW-1:0]           idx;
  logic [6:0]              frame_cnt;

  logic                    wr;
  logic                    last;
  logic [FW-1:0]           fill_next;
  logic [AW-1:0]           rd_addr;

  // Fill counts from the frame start, so the buffer refuses writes exactly
  // when the next write would land on the oldest sample still needed.
  assign di_rdy    = (fill < FW'(DEPTH)) && (state != DONE);
  assign wr        = di_en && di_rdy;
  assign last      = (state == EMIT) && (idx == IW'(FRAME_LEN - 1));
  assign fill_next = fill + FW'(wr) - (last ? FW'(HOP) : '0);
  assign rd_addr   = fs + AW'(idx);

  // Sample storage write port.
  // NOTE: the buffer array has no reset; only pointers and fill define
  // which entries are meaningful, so resetting storage would be wasted logic.
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= data_i;
  end

  // Pointer/fill bookkeeping, frame sequencing FSM and registered outputs.
  // NOTE: every state register uses non-blocking assignment so all updates
  // in this block see the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= WAIT;
      wp            <= '0;
      fs            <= '0;
      fill          <= '0;
      idx           <= '0;
      frame_cnt     <= '0;
      do_en         <= 1'b0;
      data_o        <= '0;
      out_group_num <= '0;
      out_group_idx <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      fill  <= fill_next;
      do_en <= (state == EMIT);

      if (state == EMIT) begin
        data_o        <= mem[rd_addr];
        out_group_idx <= idx;
        out_group_num <= frame_cnt;
      end

      case (state)
        WAIT: begin
          // Look at fill including this cycle's write so a frame starts
          // reading the cycle right after its last sample lands.
          if (fill_next >= FW'(FRAME_LEN)) begin
            state <= EMIT;
            idx   <= '0;
          end
        end
        EMIT: begin
          idx <= idx + 1'b1;
          if (last) begin
            fs        <= fs + AW'(HOP);
            frame_cnt <= frame_cnt + 1'b1;
            state     <= (frame_cnt == 7'(NUM_FRAMES - 1)) ? DONE : WAIT;
          end
        end
        default: state <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_segmenter.sv
// Self-checking bench for frame_segmenter with a ramp source and a
// scoreboard of expected framed samples.
module tb_frame_segmenter;

  localparam int I_BW = 8;
  localparam int FL   = 32;
  localparam int HOP  = 16;
  localparam int NF   = 20;
  localparam int IW   = $clog2(FL);
  localparam int MASK = (1 << I_BW) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   di_en = 1'b0;
  logic signed [I_BW-1:0] data_i = '0;
  logic                   di_rdy;
  logic                   do_en;
  logic signed [I_BW-1:0] data_o;
  logic [6:0]             out_group_num;
  logic [IW-1:0]          out_group_idx;

  frame_segmenter #(
    .I_BW(I_BW), .FRAME_LEN(FL), .HOP(HOP), .NUM_FRAMES(NF)
  ) dut (
    .clk(clk), .rst(rst), .di_en(di_en), .data_i(data_i), .di_rdy(di_rdy),
    .do_en(do_en), .data_o(data_o), .out_group_num(out_group_num),
    .out_group_idx(out_group_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [I_BW-1:0] data;
    int              num;
    int              idx;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ramp = 0;
  int accepted = 0;
  int next_push = 0;
  int push_cyc0 = 0;
  int frames_seen = 0;
  int handshakes = 0;
  bit prev_en = 1'b0;
  int prev_idx = 0;
  bit stall_seen = 1'b0;
  bit abort_hit = 1'b0;
  logic [I_BW-1:0] last_data = '0;
  int last_num = 0;
  int last_idx = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: observe outputs at the falling edge, then drive the next input.
  task automatic step(input bit rnd);
    exp_t e;
    bit   en;
    @(negedge clk);
    cyc++;
    if (do_en) begin
      handshakes++;
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("data", 32'($unsigned(data_o)), 32'(e.data));
        check("num", 32'(out_group_num), 32'(e.num));
        check("idx", 32'(out_group_idx), 32'(e.idx));
        if (e.num == 0 && e.idx == 0) check("first_lat", 32'(cyc - push_cyc0), 32'd2);
        if (e.num == 3 && e.idx == FL / 2) abort_hit = 1'b1;
        if (e.idx == FL - 1) frames_seen++;
        last_data = e.data;
        last_num  = e.num;
        last_idx  = e.idx;
      end
    end else begin
      check("hold_data", 32'($unsigned(data_o)), 32'(last_data));
      check("hold_num", 32'(out_group_num), 32'(last_num));
      check("hold_idx", 32'(out_group_idx), 32'(last_idx));
    end
    if (prev_en && prev_idx != FL - 1) check("no_gap", 32'(do_en), 32'd1);
    if (prev_en && prev_idx == FL - 1) check("frame_gap", 32'(do_en), 32'd0);
    prev_en  = do_en;
    prev_idx = int'(out_group_idx);

    // Buffer full means exactly 2*FL samples held since the frame start.
    if (!di_rdy && !stall_seen && frames_seen < NF) begin
      stall_seen = 1'b1;
      check("stall_hop", 32'(accepted % HOP), 32'd0);
      check("stall_min", 32'(accepted >= 2 * FL), 32'd1);
    end

    en     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    di_en  = en;
    data_i = I_BW'(ramp);
    if (en && di_rdy) begin
      ramp++;
      accepted++;
      if (next_push < NF && accepted == FL + next_push * HOP) begin
        if (next_push == 0) push_cyc0 = cyc;
        for (int i = 0; i < FL; i++) begin
          e.data = I_BW'((next_push * HOP + i) & MASK);
          e.num  = next_push;
          e.idx  = i;
          sb.push_back(e);
        end
        next_push++;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_do_en"}, 32'(do_en), 32'd0);
    check({tag, "_data"}, 32'($unsigned(data_o)), 32'd0);
    check({tag, "_num"}, 32'(out_group_num), 32'd0);
    check({tag, "_idx"}, 32'(out_group_idx), 32'd0);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst   = 1'b0;
    di_en = 1'b0;
    #1;
    check_reset_outputs("rst");
    check("rst_rdy", 32'(di_rdy), 32'd1);
    repeat (n) begin
      @(negedge clk);
      check_reset_outputs("rst_hold");
    end
    rst = 1'b1;
    sb.delete();
    ramp = 0; accepted = 0; next_push = 0; frames_seen = 0; handshakes = 0;
    prev_en = 1'b0; prev_idx = 0; abort_hit = 1'b0;
    last_data = '0; last_num = 0; last_idx = 0;
  endtask

  task automatic run_to_done(input bit rnd, input string tag);
    int guard = 0;
    while (frames_seen < NF && guard < 20000) begin
      step(rnd);
      guard++;
    end
    check({tag, "_frames"}, 32'(frames_seen), 32'(NF));
    repeat (10) begin
      step(1'b0);
      check({tag, "_done_en"}, 32'(do_en), 32'd0);
      check({tag, "_done_rdy"}, 32'(di_rdy), 32'd0);
    end
    check({tag, "_handshakes"}, 32'(handshakes), 32'(NF * FL));
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int guard;
    apply_reset(3);

    // Continuous ramp: overlap, back-pressure and halt after NF frames.
    run_to_done(1'b0, "cont");
    check("stall_seen", 32'(stall_seen), 32'd1);

    // Random valid, aborted mid-frame by reset, then a fresh full run.
    apply_reset(2);
    guard = 0;
    while (!abort_hit && guard < 20000) begin
      step(1'b1);
      guard++;
    end
    check("abort_reached", 32'(abort_hit), 32'd1);
    apply_reset(3);
    run_to_done(1'b1, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
